// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serializes bytes from NREQ requesters onto one UART
// transmitter, handshaking on its end flag with a bounded wait and sticky timeout.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int NBIT    = 8,
  parameter int TIMEOUT = 256,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*NBIT-1:0] req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 tx_transmit,
  output logic [NBIT-1:0]      tx_data,
  output logic                 tx_clr_n,
  input  logic                 tx_end_flag,
  output logic                 busy,
  output logic [IDW-1:0]       cur_id,
  output logic                 timeout_err,
  input  logic                 err_clr
);

  // state | meaning
  // IDLE  | pick next requester, or clear a stale end flag
  // SEND  | byte latched, gnt pulsed, transmit started
  // WAIT  | transmit held until end flag or timeout
  // CLEAR | end flag cleared, done pulsed for a real job
  typedef enum logic [1:0] {IDLE, SEND, WAIT, CLEAR} state_t;

  localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

  state_t          state, state_nxt;
  logic [IDW-1:0]  last_id, last_id_nxt;
  logic [IDW-1:0]  cur_id_nxt;
  logic [IDW-1:0]  win_id, cand;
  logic            win_found;
  logic [NBIT-1:0] tx_data_nxt;
  logic [CW-1:0]   wait_cnt, wait_cnt_nxt;
  logic            stale, stale_nxt;
  logic            timeout_err_nxt;
  logic [NBIT-1:0] req_byte [NREQ];
  logic [NREQ-1:0] cur_onehot;

  for (genvar i = 0; i < NREQ; i++) begin : g_byte
    assign req_byte[i] = req_data[i*NBIT +: NBIT];
  end

  assign cur_onehot = NREQ'(1) << cur_id;

  // Search starts one past the last winner so a held request cannot starve others.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = last_id;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == ID_LAST) ? '0 : cand + IDW'(1);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    last_id_nxt     = last_id;
    cur_id_nxt      = cur_id;
    tx_data_nxt     = tx_data;
    wait_cnt_nxt    = wait_cnt;
    stale_nxt       = stale;
    timeout_err_nxt = err_clr ? 1'b0 : timeout_err;
    gnt             = '0;
    done            = '0;
    tx_transmit     = 1'b0;
    tx_clr_n        = 1'b1;
    busy            = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (tx_end_flag) begin
          state_nxt = CLEAR;
          stale_nxt = 1'b1;
        end else if (win_found) begin
          state_nxt   = SEND;
          last_id_nxt = win_id;
          cur_id_nxt  = win_id;
          tx_data_nxt = req_byte[win_id];
          stale_nxt   = 1'b0;
        end
      end
      SEND: begin
        gnt          = cur_onehot;
        tx_transmit  = 1'b1;
        wait_cnt_nxt = '0;
        state_nxt    = WAIT;
      end
      WAIT: begin
        // transmit stays high so the transmitter cannot restart on its own flag
        tx_transmit = 1'b1;
        if (tx_end_flag) begin
          state_nxt = CLEAR;
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt       = CLEAR;
          timeout_err_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end
      CLEAR: begin
        tx_clr_n = 1'b0;
        if (!stale) done = cur_onehot;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_id     <= ID_LAST;
      cur_id      <= '0;
      tx_data     <= '0;
      wait_cnt    <= '0;
      stale       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_id     <= last_id_nxt;
      cur_id      <= cur_id_nxt;
      tx_data     <= tx_data_nxt;
      wait_cnt    <= wait_cnt_nxt;
      stale       <= stale_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a randomized phase, checked
// against a rotating-priority model and a simple transmitter model.
module tb_uart_tx_arbiter;
  localparam int NREQ    = 4;
  localparam int NBIT    = 8;
  localparam int TIMEOUT = 256;
  localparam int IDW     = $clog2(NREQ);

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*NBIT-1:0] req_data;
  logic [NREQ-1:0]      gnt, done;
  logic                 tx_transmit, tx_clr_n, tx_end_flag, busy, timeout_err, err_clr;
  logic [NBIT-1:0]      tx_data;
  logic [IDW-1:0]       cur_id;

  uart_tx_arbiter #(.NREQ(NREQ), .NBIT(NBIT), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt), .done(done),
    .tx_transmit(tx_transmit), .tx_data(tx_data), .tx_clr_n(tx_clr_n),
    .tx_end_flag(tx_end_flag), .busy(busy), .cur_id(cur_id),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  int cyc = 0;
  logic [NREQ-1:0]      req_edge;
  logic [NREQ*NBIT-1:0] data_edge;
  logic                 rst_edge;
  int  m_last = NREQ - 1;
  bit  pending = 0;
  logic [NBIT-1:0] m_byte = '0;
  int  last_gnt_cyc = -100, done_cyc = -1;
  int  gnt_cnt = 0, done_cnt = 0, clr_cnt = 0;
  int  order_q[$];
  int  tx_cnt = -1, tx_lat = 5;
  bit  rand_lat = 0, reseed_on_gnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
    logic [NREQ-1:0] rv;
    for (int k = 1; k <= NREQ; k++) begin
      rv = r >> ((last + k) % NREQ);
      if (rv[0]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int w);
    return (w < 0) ? '0 : NREQ'(1) << w;
  endfunction

  function automatic logic [NBIT-1:0] byte_of(input logic [NREQ*NBIT-1:0] d, input int w);
    return (w < 0) ? '0 : d[w*NBIT +: NBIT];
  endfunction

  // One clock: advance, check grant/done events, then let the transmitter model react.
  task automatic tick();
    int w;
    req_edge  = req;
    data_edge = req_data;
    rst_edge  = reset;
    @(posedge clk); #1;
    cyc++;
    if (rst_edge) begin
      m_last = NREQ - 1;
      pending = 0;
      last_gnt_cyc = -100;
    end
    if (gnt != '0) begin
      w = rr_pick(m_last, req_edge);
      chk("gnt_winner", gnt, onehot(w));
      chk("gnt_data", tx_data, byte_of(data_edge, w));
      chk("gnt_cur_id", cur_id, w);
      chk("gnt_gap_ge4", (cyc - last_gnt_cyc) >= 4, 1);
      chk("gnt_while_pending", pending, 0);
      m_last = w;
      m_byte = byte_of(data_edge, w);
      pending = 1;
      last_gnt_cyc = cyc;
      gnt_cnt++;
      order_q.push_back(w);
      if (reseed_on_gnt && w >= 0) req_data[w*NBIT +: NBIT] = NBIT'($urandom);
    end
    if (done != '0) begin
      chk("done_id", done, onehot(m_last));
      chk("done_has_job", pending, 1);
      chk("done_data_held", tx_data, m_byte);
      pending = 0;
      done_cnt++;
      done_cyc = cyc;
    end
    if (!tx_clr_n) clr_cnt++;
    if (!tx_clr_n) begin
      tx_end_flag = 1'b0;
      tx_cnt = -1;
    end else if (tx_transmit && !tx_end_flag && tx_cnt < 0 && tx_lat > 0) begin
      tx_cnt = rand_lat ? int'($urandom_range(1, 12)) : tx_lat;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
    end
    if (tx_cnt == 0) begin
      tx_end_flag = 1'b1;
      tx_cnt = -1;
    end
  endtask

  task automatic wait_gnt(input int budget);
    int g0, n;
    g0 = gnt_cnt;
    n = 0;
    while (gnt_cnt == g0 && n < budget) begin tick(); n++; end
    chk("wait_gnt_in_budget", gnt_cnt != g0, 1);
  endtask

  task automatic wait_done(input int budget);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin tick(); n++; end
    chk("wait_done_in_budget", done_cnt != d0, 1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((busy || pending) && n < budget) begin tick(); n++; end
    chk("drain_idle", {busy, pending}, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_tx_transmit", tx_transmit, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_clr_n", tx_clr_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cur_id", cur_id, 0);
    chk("rst_timeout_err", timeout_err, 0);
  endtask

  int gc, dc0, g_gnt0, g_done0, n;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1; req = '0; req_data = '0; tx_end_flag = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    chk_reset_vals();

    // single request, flag 100 cycles after transmit
    req_data[2*NBIT +: NBIT] = 8'hA5;
    req = 4'b0100;
    reset = 1'b0;
    tx_lat = 100;
    clr_cnt = 0;
    wait_gnt(10);
    chk("a_gnt2", gnt, 4'b0100);
    chk("a_busy_send", busy, 1);
    chk("a_transmit", tx_transmit, 1);
    req = '0;
    gc = last_gnt_cyc;
    wait_done(200);
    chk("a_done_latency", done_cyc - gc, 101);
    chk("a_done2", done, 4'b0100);
    chk("a_tx_data_clear", tx_data, 8'hA5);
    tick();
    chk("a_busy_back", busy, 0);
    chk("a_one_clr_pulse", clr_cnt, 1);

    // all four held from reset
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    req = 4'b1111;
    req_data = 32'h44332211;
    tx_lat = 3;
    reseed_on_gnt = 1;
    order_q.delete();
    n = 0;
    while (order_q.size() < 5 && n < 100) begin tick(); n++; end
    chk("b_five_grants", order_q.size() >= 5, 1);
    for (int i = 0; i < 5; i++)
      chk("b_order", (i < order_q.size()) ? order_q[i] : -1, exp_order[i]);
    req = '0;
    reseed_on_gnt = 0;
    drain(100);

    // stale flag at reset release
    reset = 1'b1;
    tick();
    tx_end_flag = 1'b1;
    tick();
    reset = 1'b0;
    dc0 = done_cnt;
    clr_cnt = 0;
    tick();
    chk("c_clr_low", tx_clr_n, 0);
    chk("c_no_done", done, 0);
    chk("c_no_gnt", gnt, 0);
    chk("c_busy", busy, 1);
    tick();
    chk("c_idle", busy, 0);
    chk("c_clr_high", tx_clr_n, 1);
    tick();
    chk("c_single_clear", clr_cnt, 1);
    chk("c_done_count", done_cnt, dc0);

    // timeout, then err_clr
    tx_lat = 0;
    req_data[1*NBIT +: NBIT] = 8'h3C;
    req = 4'b0010;
    wait_gnt(10);
    req = '0;
    gc = last_gnt_cyc;
    dc0 = done_cnt;
    while (cyc < gc + 256) tick();
    chk("d_err_before", timeout_err, 0);
    chk("d_still_wait", tx_clr_n, 1);
    chk("d_no_early_done", done_cnt, dc0);
    tick();
    chk("d_clear_at_257", done_cyc - gc, 257);
    chk("d_done_victim", done, 4'b0010);
    chk("d_err_set", timeout_err, 1);
    tick();
    chk("d_err_sticky", timeout_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("d_err_cleared", timeout_err, 0);

    // err_clr in the same cycle the timeout fires
    req = 4'b0001;
    wait_gnt(10);
    req = '0;
    gc = last_gnt_cyc;
    while (cyc < gc + 256) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("e_set_wins", timeout_err, 1);
    chk("e_done", done, 4'b0001);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("e_cleared", timeout_err, 0);

    // reset during WAIT, flag left set by transmitter
    tx_lat = 50;
    req_data[3*NBIT +: NBIT] = 8'h5A;
    req = 4'b1000;
    wait_gnt(10);
    req = '0;
    repeat (5) tick();
    chk("f_busy_wait", busy, 1);
    dc0 = done_cnt;
    reset = 1'b1;
    tick();
    chk_reset_vals();
    tx_end_flag = 1'b1;
    tx_cnt = -1;
    tick();
    reset = 1'b0;
    tick();
    chk("f_stale_clear", tx_clr_n, 0);
    chk("f_no_done", done, 0);
    tick();
    chk("f_idle", busy, 0);
    chk("f_done_count", done_cnt, dc0);

    // randomized traffic
    rand_lat = 1;
    tx_lat = 1;
    reseed_on_gnt = 1;
    req_data = $urandom;
    g_gnt0 = gnt_cnt;
    g_done0 = done_cnt;
    n = 0;
    while (gnt_cnt - g_gnt0 < 40 && n < 3000) begin
      if ($urandom_range(0, 5) == 0) req = NREQ'($urandom);
      tick();
      n++;
    end
    req = '0;
    drain(100);
    chk("g_progress", gnt_cnt - g_gnt0 >= 40, 1);
    chk("g_done_per_gnt", done_cnt - g_done0, gnt_cnt - g_gnt0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
